// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan cluster sequencer.
//   MODE_*        : 2-bit {se1,se0} mode select encodings driven to the chain
//   scan_state_t  : sequencer state encoding
package scan_ctrl_pkg;

    localparam logic [1:0] MODE_FUNC    = 2'b00;  // functional D path
    localparam logic [1:0] MODE_SHIFT   = 2'b01;  // scan-in (Si) path
    localparam logic [1:0] MODE_HOLD    = 2'b10;  // keep contents
    localparam logic [1:0] MODE_CAPTURE = 2'b11;  // capture D into the chain

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_shift_cnt.sv
// Shift counter shared by the LOAD and UNLOAD phases.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   clr        : return the count to zero (wins over inc)
//   inc        : advance the count by one
//   cnt        : current count
//   tc         : terminal count, high when cnt == CHAIN_LEN-1
module scan_shift_cnt
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_cluster_ctrl.sv
// Sequencer for one scan cluster. In IDLE the chain runs functionally; on
// start a pattern is shifted in, one capture clock is applied, the response
// is shifted out and compared against the expected value.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   start, abort     : run request (IDLE only) / terminate a run in progress
//   func_en          : functional enable, forwarded to en while IDLE
//   pattern_in       : stimulus, MSB lands in the last flop of the chain
//   expect_in        : expected captured response
//   scl              : serial output of the chain
//   sci, se1, se0, en: serial input, mode select and enable to the chain
//   busy, done, pass : run in progress / completion pulse / compare result
//   resp_out         : unloaded response
module scan_cluster_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 func_en,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expect_in,
    input  logic                 scl,
    output logic                 sci,
    output logic                 se1,
    output logic                 se0,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] resp_out
);

    scan_state_t          state;
    logic [CHAIN_LEN-1:0] pat;
    logic [CHAIN_LEN-1:0] exp_val;
    logic [CNT_W-1:0]     cnt;
    logic                 tc;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic [CHAIN_LEN-1:0] resp_next;
    logic [1:0]           mode;

    // The counter only runs mid-phase; it is zero on entry to every phase
    // because it is held clear in all other states and on terminal count.
    assign cnt_inc = ((state == LOAD) || (state == UNLOAD)) && !tc && !abort;
    assign cnt_clr = !cnt_inc;

    scan_shift_cnt #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .tc    (tc)
    );

    assign resp_next = {resp_out[CHAIN_LEN-2:0], scl};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pat      <= '0;
            exp_val  <= '0;
            resp_out <= '0;
            pass     <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            // Partial response is left in resp_out for debug.
            state <= IDLE;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        pat     <= pattern_in;
                        exp_val <= expect_in;
                        pass    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (tc) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state <= UNLOAD;
                end
                UNLOAD: begin
                    resp_out <= resp_next;
                    if (tc) begin
                        state <= DONE;
                        // Compare the completed response now so pass is
                        // already valid while done is high.
                        pass  <= (resp_next == exp_val);
                    end
                end
                DONE: begin
                    pass  <= (resp_out == exp_val);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode; en follows func_en directly while IDLE.
    always_comb begin
        mode = MODE_FUNC;
        en   = func_en;
        sci  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                mode = MODE_FUNC;
                en   = func_en;
            end
            LOAD: begin
                mode = MODE_SHIFT;
                en   = 1'b1;
                busy = 1'b1;
                // MSB first so it ends up in the last flop.
                sci  = pat[CNT_W'(CHAIN_LEN - 1) - cnt];
            end
            CAPTURE: begin
                mode = MODE_CAPTURE;
                en   = 1'b1;
                busy = 1'b1;
            end
            UNLOAD: begin
                mode = MODE_SHIFT;
                en   = 1'b1;
                busy = 1'b1;
            end
            DONE: begin
                mode = MODE_HOLD;
                en   = 1'b0;
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                mode = MODE_FUNC;
                en   = func_en;
            end
        endcase
    end

    assign se1 = mode[1];
    assign se0 = mode[0];

endmodule

// File: tb/tb_scan_cluster_ctrl.sv
// Bench for scan_cluster_ctrl with a behavioural 3-flop scan chain.
module tb_scan_cluster_ctrl;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         func_en = 1'b0;
    logic [N-1:0] pattern_in = '0;
    logic [N-1:0] expect_in = '0;
    logic         scl;
    logic         sci, se1, se0, en, busy, done, pass;
    logic [N-1:0] resp_out;

    int tests = 0;
    int fails = 0;

    // Behavioural chain: ff[0] takes sci, ff[N-1] drives scl.
    logic [N-1:0] ff = '0;
    logic [N-1:0] chain_d = 3'b101;
    logic         bypass = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en) begin
            case ({se1, se0})
                2'b00:   ff <= chain_d;
                2'b01:   ff <= {ff[N-2:0], sci};
                2'b11:   if (!bypass) ff <= chain_d;
                default: ff <= ff;
            endcase
        end
    end

    assign scl = ff[N-1];

    scan_cluster_ctrl #(.CHAIN_LEN(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .func_en    (func_en),
        .pattern_in (pattern_in),
        .expect_in  (expect_in),
        .scl        (scl),
        .sci        (sci),
        .se1        (se1),
        .se0        (se0),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .resp_out   (resp_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run. Expected response: the chain captures chain_d, or returns
    // the loaded pattern when capture is bypassed.
    task automatic run(input logic [N-1:0] p, input logic [N-1:0] e,
                       input logic [N-1:0] d, input logic byp);
        logic [N-1:0] want;
        int edges;
        chain_d    = d;
        bypass     = byp;
        want       = byp ? p : d;
        pattern_in = p;
        expect_in  = e;
        start      = 1'b1;
        tick();                       // edge 0
        start      = 1'b0;
        pattern_in = N'($urandom);    // must already be latched
        expect_in  = N'($urandom);
        chk("busy_run", busy, 1);
        for (int k = 0; k < N; k++) begin
            chk("load_mode", {se1, se0}, 2'b01);
            chk("load_sci", sci, p[N-1-k]);
            tick();
        end
        chk("cap_mode", {se1, se0}, 2'b11);
        tick();
        edges = N + 1;
        while (!done && edges < 60) begin
            tick();
            edges++;
        end
        chk("done_edge", edges, 2 * N + 1);
        chk("resp", resp_out, want);
        chk("pass", pass, (want == e));
        chk("done_mode", {se1, se0}, 2'b10);
        chk("done_en", en, 0);
        tick();
        chk("done_1cyc", done, 0);
        chk("busy_end", busy, 0);
        chk("pass_hold", pass, (want == e));
        chk("resp_hold", resp_out, want);
    endtask

    int npulse;
    int first_done;
    logic [N-1:0] rp, rd, re;
    logic rb;

    initial begin
        // Reset state
        func_en = 1'b1;
        tick();
        tick();
        chk("rst_mode", {se1, se0}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_resp", resp_out, 0);
        chk("rst_sci", sci, 0);
        chk("rst_en", en, 1);
        reset   = 1'b1;
        func_en = 1'b0;
        tick();

        // Directed runs
        run(3'b011, 3'b101, 3'b101, 1'b0);
        run(3'b011, 3'b111, 3'b101, 1'b0);
        run(3'b110, 3'b110, 3'b101, 1'b1);

        // Abort in the 2nd UNLOAD cycle
        chain_d    = 3'b101;
        bypass     = 1'b0;
        pattern_in = 3'b011;
        expect_in  = 3'b101;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N + 2; k++) tick();
        chk("abort_in_unload", {se1, se0}, 2'b01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pass", pass, 0);
        npulse = 0;
        for (int k = 0; k < 2 * N + 4; k++) begin
            if (done) npulse++;
            tick();
        end
        chk("abort_nodone", npulse, 0);
        run(3'b011, 3'b101, 3'b101, 1'b0);

        // start pulsed during LOAD is ignored
        pattern_in = 3'b100;
        expect_in  = 3'b101;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        npulse = 0;
        first_done = -1;
        for (int k = 3; k < 3 * N + 8; k++) begin
            if (done) begin
                npulse++;
                if (first_done < 0) first_done = k - 1;
            end
            tick();
        end
        chk("glitch_pulses", npulse, 1);
        chk("glitch_edge", first_done, 2 * N + 1);
        chk("glitch_pass", pass, 1);

        // start and abort together in IDLE: run starts
        run(3'b001, 3'b000, 3'b101, 1'b0);
        abort = 1'b1;
        start = 1'b1;
        pattern_in = 3'b010;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 1);
        for (int k = 0; k < 2 * N + 4; k++) tick();
        chk("sa_resp", resp_out, 3'b101);

        // Randomized runs
        for (int i = 0; i < 12; i++) begin
            rp = N'($urandom);
            rd = N'($urandom);
            rb = 1'($urandom_range(0, 1));
            re = $urandom_range(0, 1) ? (rb ? rp : rd) : N'($urandom);
            func_en = 1'($urandom_range(0, 1));
            #1;
            chk("idle_en", en, func_en);
            run(rp, re, rd, rb);
        end

        // Reset mid-LOAD
        run(3'b011, 3'b101, 3'b101, 1'b0);
        func_en    = 1'b1;
        pattern_in = 3'b110;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_mode", {se1, se0}, 2'b00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_resp", resp_out, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_en1", en, 1);
        func_en = 1'b0;
        #1;
        chk("mid_rst_en0", en, 0);
        func_en = 1'b1;
        #1;
        chk("mid_rst_en1b", en, 1);
        tick();
        chk("mid_rst_stay", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
